// File: rtl/bias_pkg.sv
// Shared constants, fixed layer table and FSM state type for the bias/activation stage.
package bias_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int NUM_BIAS   = 19;
    localparam int NUM_LAYERS = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACC = 2'd1,
        ST_EMIT     = 2'd2
    } state_e;

    // Neuron count per layer; the counts sum to NUM_BIAS.
    function automatic logic [2:0] layer_count(input logic [2:0] layer);
        case (layer)
            3'd0:    layer_count = 3'd4;
            3'd1:    layer_count = 3'd2;
            3'd2:    layer_count = 3'd1;
            3'd3:    layer_count = 3'd1;
            3'd4:    layer_count = 3'd1;
            3'd5:    layer_count = 3'd2;
            3'd6:    layer_count = 3'd4;
            3'd7:    layer_count = 3'd4;
            default: layer_count = 3'd1;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] layer_base(input logic [2:0] layer);
        case (layer)
            3'd0:    layer_base = 5'd0;
            3'd1:    layer_base = 5'd4;
            3'd2:    layer_base = 5'd6;
            3'd3:    layer_base = 5'd7;
            3'd4:    layer_base = 5'd8;
            3'd5:    layer_base = 5'd9;
            3'd6:    layer_base = 5'd11;
            3'd7:    layer_base = 5'd15;
            default: layer_base = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/bias_sat_relu.sv
// Saturating bias add followed by the activation function.
// Activation is ReLU when BIAS_ACT_RELU_EN is defined, identity otherwise.
module bias_sat_relu import bias_pkg::*; #(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] bias_i,
    output logic [W-1:0] act_o
);

    logic [W:0]   sum;
    logic [W-1:0] sat;

    // One extra bit of headroom; the top two bits disagree exactly on overflow.
    always_comb begin
        sum = {acc_i[W-1], acc_i} + {bias_i[W-1], bias_i};
        if (sum[W] != sum[W-1]) begin
            sat = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            sat = sum[W-1:0];
        end
`ifdef BIAS_ACT_RELU_EN
        if (sat[W-1]) begin
            act_o = '0;
        end else begin
            act_o = sat;
        end
`else
        act_o = sat;
`endif
    end

endmodule

// File: rtl/bias_act_stage.sv
// Per-layer bias add + activation stage: one accumulator in, one activation out per neuron.
// Optional ReLU selected by BIAS_ACT_RELU_EN (see bias_sat_relu).
module bias_act_stage import bias_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              res_i,
    input  logic              start_i,
    input  logic [2:0]        layer_sel_i,
    input  logic [DATA_W-1:0] acc_in_i,
    input  logic              acc_valid_i,
    output logic              acc_ready_o,
    output logic [ADDR_W-1:0] addr_mem_b_o,
    input  logic [DATA_W-1:0] mem_b_i,
    output logic [DATA_W-1:0] act_out_o,
    output logic              act_valid_o,
    input  logic              act_ready_i,
    output logic              busy_o,
    output logic              layer_done_o
);

    state_e            state_q, state_d;
    logic [2:0]        layer_q, layer_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] act_q, act_d;
    logic              act_valid_q, act_valid_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] act_f;
    logic [2:0]        last_idx;

    bias_sat_relu #(.W(DATA_W)) u_sat_relu (
        .acc_i  (acc_in_i),
        .bias_i (mem_b_i),
        .act_o  (act_f)
    );

    assign last_idx = layer_count(layer_q) - 3'd1;

    // Next-state logic for the layer sequencer.
    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        idx_d       = idx_q;
        act_d       = act_q;
        act_valid_d = act_valid_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    layer_d = layer_sel_i;
                    idx_d   = 3'd0;
                    state_d = ST_WAIT_ACC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ACC: begin
                if (acc_valid_i) begin
                    act_d       = act_f;
                    act_valid_d = 1'b1;
                    state_d     = ST_EMIT;
                end else begin
                    state_d = ST_WAIT_ACC;
                end
            end
            ST_EMIT: begin
                if (act_ready_i) begin
                    act_valid_d = 1'b0;
                    if (idx_q == last_idx) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_WAIT_ACC;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                act_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any layer in flight silently.
    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q     <= ST_IDLE;
            layer_q     <= 3'd0;
            idx_q       <= 3'd0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            idx_q       <= idx_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
            done_q      <= done_d;
        end
    end

    assign acc_ready_o  = (state_q == ST_WAIT_ACC);
    assign busy_o       = (state_q != ST_IDLE);
    assign act_out_o    = act_q;
    assign act_valid_o  = act_valid_q;
    assign layer_done_o = done_q;
    assign addr_mem_b_o = (state_q == ST_IDLE) ? '0
                        : ADDR_W'(layer_base(layer_q)) + ADDR_W'(idx_q);

endmodule

// File: tb/tb_bias_act_stage.sv
// Randomized + directed bench for bias_act_stage against a transaction-level reference model.
module tb_bias_act_stage;

    logic        clk = 1'b0;
    logic        res_i = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  layer_sel_i = 3'd0;
    logic [31:0] acc_in_i = 32'd0;
    logic        acc_valid_i = 1'b0;
    logic        acc_ready_o;
    logic [4:0]  addr_mem_b_o;
    logic [31:0] mem_b_i;
    logic [31:0] act_out_o;
    logic        act_valid_o;
    logic        act_ready_i = 1'b0;
    logic        busy_o;
    logic        layer_done_o;

    logic [31:0] bias_mem [32];
    assign mem_b_i = bias_mem[addr_mem_b_o];

    bias_act_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i        (clk),
        .res_i        (res_i),
        .start_i      (start_i),
        .layer_sel_i  (layer_sel_i),
        .acc_in_i     (acc_in_i),
        .acc_valid_i  (acc_valid_i),
        .acc_ready_o  (acc_ready_o),
        .addr_mem_b_o (addr_mem_b_o),
        .mem_b_i      (mem_b_i),
        .act_out_o    (act_out_o),
        .act_valid_o  (act_valid_o),
        .act_ready_i  (act_ready_i),
        .busy_o       (busy_o),
        .layer_done_o (layer_done_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int tb_cnt [8] = '{4, 2, 1, 1, 1, 2, 4, 4};
    int tb_base [8];

    // Reference model state (transaction level)
    bit          m_en = 1'b0;
    bit          m_active = 1'b0;
    int          m_layer = 0;
    int          m_idx = 0;
    bit          m_done_pending = 1'b0;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          got_addr [$];
    int          done_cnt = 0;

    function automatic logic [31:0] ref_f(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        else if (s < -64'sd2147483648) s = -64'sd2147483648;
`ifdef BIAS_ACT_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[31:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic monitor();
        int ea;
        ea = m_active ? tb_base[m_layer] + m_idx : 0;
        if (m_en) begin
            chk("busy", 32'(busy_o), 32'(m_active));
            chk("addr", 32'(addr_mem_b_o), 32'(ea));
            chk("acc_ready", 32'(acc_ready_o), 32'(m_active && exp_q.size() == 0));
            chk("act_valid", 32'(act_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("act_out", act_out_o, exp_q[0]);
            chk("layer_done", 32'(layer_done_o), 32'(m_done_pending));
        end
        if (layer_done_o === 1'b1) done_cnt++;
        m_done_pending = 1'b0;
        if (res_i) begin
            m_active = 1'b0;
            m_idx = 0;
            exp_q.delete();
        end else if (!m_active) begin
            if (start_i) begin
                m_active = 1'b1;
                m_layer  = int'(layer_sel_i);
                m_idx    = 0;
            end
        end else if (exp_q.size() == 0) begin
            if (acc_valid_i) begin
                exp_q.push_back(ref_f(acc_in_i, bias_mem[ea]));
                got_addr.push_back(int'(addr_mem_b_o));
            end
        end else if (act_ready_i) begin
            got_q.push_back(act_out_o);
            void'(exp_q.pop_front());
            if (m_idx == tb_cnt[m_layer] - 1) begin
                m_active = 1'b0;
                m_done_pending = 1'b1;
            end else begin
                m_idx++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL timeout %s at %0t", nm, $time);
    endtask

    // Run n neurons of layer l; hold Act_ready low for 'hold' cycles in EMIT.
    task automatic feed(input logic [2:0] l, input int n, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] a3, input int hold, input bit mid);
        logic [31:0] av [4];
        int g;
        av = '{a0, a1, a2, a3};
        start_i = 1'b1; layer_sel_i = l;
        tick();
        start_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            acc_valid_i = 1'b1; acc_in_i = av[k];
            if (mid && k == 1) start_i = 1'b1;
            g = 0;
            while (!acc_ready_o && g < 20) begin tick(); g++; end
            if (g >= 20) timeout("acc_handshake");
            tick();
            start_i = 1'b0; acc_valid_i = 1'b0;
            repeat (hold) tick();
            act_ready_i = 1'b1;
            g = 0;
            while (!act_valid_o && g < 20) begin tick(); g++; end
            if (g >= 20) timeout("act_handshake");
            tick();
            act_ready_i = 1'b0;
        end
        tick();
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFFFFFF - 32'($urandom_range(0, 64));
            1:       return 32'h80000000 + 32'($urandom_range(0, 64));
            2:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int d0;
        int acc_b;
        acc_b = 0;
        for (int i = 0; i < 8; i++) begin tb_base[i] = acc_b; acc_b += tb_cnt[i]; end
        for (int i = 0; i < 32; i++) bias_mem[i] = 32'd0;
        tick(); tick();
        m_en = 1'b1;
        res_i = 1'b0;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_act_out", act_out_o, 32'd0);
        chk("rst_act_valid", 32'(act_valid_o), 32'd0);
        chk("rst_addr", 32'(addr_mem_b_o), 32'd0);

        // Layer 0 example
        bias_mem[0] = 32'd10; bias_mem[1] = -32'sd300; bias_mem[2] = 32'd5; bias_mem[3] = 32'd0;
        got_q.delete(); got_addr.delete(); d0 = done_cnt;
        feed(3'd0, 4, 32'd100, 32'd200, -32'sd5, 32'd7, 0, 1'b0);
        chk("l0_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            chk("l0_out0", got_q[0], 32'd110);
`ifdef BIAS_ACT_RELU_EN
            chk("l0_out1", got_q[1], 32'd0);
`else
            chk("l0_out1", got_q[1], 32'hFFFFFF9C);
`endif
            chk("l0_out2", got_q[2], 32'd0);
            chk("l0_out3", got_q[3], 32'd7);
        end
        if (got_addr.size() == 4) chk("l0_addr3", 32'(got_addr[3]), 32'd3);
        chk("l0_done", 32'(done_cnt), 32'(d0 + 1));

        // Positive saturation with a 5-cycle downstream stall
        bias_mem[6] = 32'h20;
        got_q.delete();
        feed(3'd2, 1, 32'h7FFFFFF0, 32'd0, 32'd0, 32'd0, 5, 1'b0);
        if (got_q.size() == 1) chk("sat_pos", got_q[0], 32'h7FFFFFFF);
        else timeout("sat_pos_count");

        // Negative saturation and plain negative pass-through
        bias_mem[7] = 32'hFFFFFFFF; bias_mem[8] = 32'd0;
        got_q.delete();
        feed(3'd3, 1, 32'h80000000, 32'd0, 32'd0, 32'd0, 0, 1'b0);
        feed(3'd4, 1, -32'sd100, 32'd0, 32'd0, 32'd0, 2, 1'b0);
        if (got_q.size() == 2) begin
`ifdef BIAS_ACT_RELU_EN
            chk("sat_neg", got_q[0], 32'd0);
            chk("neg_pass", got_q[1], 32'd0);
`else
            chk("sat_neg", got_q[0], 32'h80000000);
            chk("neg_pass", got_q[1], 32'hFFFFFF9C);
`endif
        end else timeout("neg_count");

        // Layer 7 with a Start pulsed mid-layer
        got_q.delete(); got_addr.delete(); d0 = done_cnt;
        feed(3'd7, 4, 32'd1, 32'd2, 32'd3, 32'd4, 1, 1'b1);
        chk("l7_count", 32'(got_q.size()), 32'd4);
        if (got_addr.size() == 4) begin
            chk("l7_addr0", 32'(got_addr[0]), 32'd15);
            chk("l7_addr3", 32'(got_addr[3]), 32'd18);
        end
        chk("l7_done", 32'(done_cnt), 32'(d0 + 1));
        tick();
        chk("l7_idle", 32'(busy_o), 32'd0);

        // Reset after 2 of 4 outputs
        d0 = done_cnt;
        feed(3'd0, 2, 32'd5, 32'd6, 32'd0, 32'd0, 0, 1'b0);
        res_i = 1'b1;
        tick();
        res_i = 1'b0;
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_valid", 32'(act_valid_o), 32'd0);
        tick(); tick();
        chk("mid_rst_nodone", 32'(done_cnt), 32'(d0));
        got_addr.delete();
        feed(3'd0, 4, 32'd1, 32'd1, 32'd1, 32'd1, 0, 1'b0);
        if (got_addr.size() == 4) chk("restart_addr0", 32'(got_addr[0]), 32'd0);
        else timeout("restart_count");

        // Random phase
        for (int i = 0; i < 19; i++) bias_mem[i] = rnd_word();
        for (int c = 0; c < 4000; c++) begin
            start_i     = ($urandom_range(0, 7) == 0);
            layer_sel_i = 3'($urandom_range(0, 7));
            acc_valid_i = ($urandom_range(0, 1) == 1);
            acc_in_i    = rnd_word();
            act_ready_i = ($urandom_range(0, 9) < 6);
            res_i       = ($urandom_range(0, 299) == 0);
            tick();
        end
        start_i = 1'b0; acc_valid_i = 1'b0; act_ready_i = 1'b0; res_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bias_act_stage.md
BIAS_ACT_STAGE -- requirements
Module: bias_act_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of the accumulator, bias and activation data.
REQ-002 Parameter ADDR_W, default 5: width of the bias-memory address.
REQ-003 Clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Res  in  1  reset; synchronous, active-high.
REQ-005 Start  in  1  one-cycle request to process one layer; sampled only in IDLE.
REQ-006 Layer_sel  in  3  layer index 0..7; latched on an accepted Start.
REQ-007 Acc_in  in  DATA_W  signed MAC accumulator result for the current neuron.
REQ-008 Acc_valid  in  1  Acc_in valid.
REQ-009 Acc_ready  out  1  stage can accept Acc_in.
REQ-010 Addr_mem_b  out  ADDR_W  bias-memory read address.
REQ-011 Mem_b  in  DATA_W  signed bias word; combinational read of Addr_mem_b.
REQ-012 Act_out  out  DATA_W  signed activation result.
REQ-013 Act_valid  out  1  Act_out valid.
REQ-014 Act_ready  in  1  downstream accepts Act_out.
REQ-015 Busy  out  1  high in every state except IDLE.
REQ-016 Layer_done  out  1  one-cycle pulse after the last neuron of a layer is accepted downstream.

Function
REQ-017 The layer table SHALL be fixed: neuron counts 4,2,1,1,1,2,4,4 and base addresses 0,4,6,7,8,9,11,15 for layers 0..7 (19 entries in total).
REQ-018 The FSM SHALL have three states: IDLE, WAIT_ACC and EMIT.
REQ-019 IDLE: on Start, latch Layer_sel, set idx=0 and go to WAIT_ACC; in IDLE, Addr_mem_b=0.
REQ-020 Outside IDLE, Addr_mem_b SHALL equal base[layer]+idx.
REQ-021 WAIT_ACC: Acc_ready=1; on Acc_valid, register Act_out=f(sat(Acc_in+Mem_b)), then go to EMIT.
REQ-022 The sum SHALL be computed at DATA_W+1 bits and saturated to [0x80000000, 0x7FFFFFFF].
REQ-023 EMIT: Act_valid=1 and Acc_ready=0; Act_out SHALL be held stable until Act_ready.
REQ-024 EMIT with Act_ready: if idx==count-1, pulse Layer_done and go to IDLE; otherwise increment idx and go to WAIT_ACC.
REQ-025 Latency SHALL be one cycle from accumulator accept to Act_valid; throughput is at most one result per 2 cycles.
REQ-026 Start SHALL be ignored while Busy=1.
REQ-027 Layer_done SHALL coincide with the cycle IDLE is re-entered; a Start in that cycle is accepted on the following cycle.

Reset
REQ-028 Res=1 SHALL force: state IDLE, idx=0, Act_out=0, Act_valid=0, Acc_ready=0, Busy=0, Layer_done=0.
REQ-029 Reset mid-layer SHALL abandon the layer without a Layer_done pulse.

Configuration
REQ-030 With BIAS_ACT_RELU_EN defined, f(x)=max(x,0); without it, f(x)=x (the saturated sum is passed through unchanged).

Structure
REQ-031 Package bias_pkg SHALL hold DATA_W, ADDR_W, NUM_BIAS=19, NUM_LAYERS=8, the layer count and base tables, and the FSM state enum.
REQ-032 The saturating adder and ReLU SHALL live in the combinational sub-module bias_sat_relu.

Verification
REQ-033 Layer 0, with BIAS_ACT_RELU_EN defined, Acc_in 100,200,-5,7 and bias 10,-300,5,0 -> addresses 0,1,2,3; outputs 110,0,0,7; Layer_done after the 4th handshake.
REQ-034 Acc_in 0x7FFFFFF0 with bias 0x20 -> Act_out 0x7FFFFFFF.
REQ-035 Act_ready held low 5 cycles in EMIT -> Act_valid=1, Act_out stable and Acc_ready=0 for all 5 cycles.
REQ-036 Layer 7 -> addresses 15..18; a Start pulsed mid-layer is ignored, giving exactly 4 outputs.
REQ-037 Res asserted after 2 of 4 outputs -> Busy=0, Act_valid=0, no Layer_done; the next Start restarts at address base+0.
REQ-038 Without the macro: Acc_in -100 with bias 0 -> -100; Acc_in 0x80000000 with bias -1 -> 0x80000000.
